// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: widths, ALU select codes,
// response-buffer state encoding and the funct3/funct7 decode helper.
package alu_pkg;

  localparam int XLEN          = 32;
  localparam int FUNCT3_WIDTH  = 3;
  localparam int ALUCTRL_WIDTH = 4;
  localparam int NUM_REQ       = 2;
  localparam int ID_WIDTH      = 1;

  localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_AND  = 4'd2;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_OR   = 4'd3;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_XOR  = 4'd4;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLL  = 4'd5;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLTU = 4'd9;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Map the RV32 instruction fields of one request to an ALU select.
  function automatic logic [ALUCTRL_WIDTH-1:0] alu_decode(
    input logic                    arith,
    input logic [FUNCT3_WIDTH-1:0] funct3,
    input logic                    funct7_fif,
    input logic                    i_type
  );
    logic [ALUCTRL_WIDTH-1:0] sel;
    sel = ALU_ADD;
    if (arith) begin
      case (funct3)
        3'b000:  sel = (funct7_fif && !i_type) ? ALU_SUB : ALU_ADD;
        3'b001:  sel = ALU_SLL;
        3'b010:  sel = ALU_SLT;
        3'b011:  sel = ALU_SLTU;
        3'b100:  sel = ALU_XOR;
        3'b101:  sel = funct7_fif ? ALU_SRA : ALU_SRL;
        3'b110:  sel = ALU_OR;
        default: sel = ALU_AND;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters, the shared-ALU
// arbiter and the response consumer. master = requesters/consumer side,
// slave = arbiter side.
interface alu_share_arbiter_if;
  import alu_pkg::*;

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ-1:0]              req_arith;
  logic [NUM_REQ*FUNCT3_WIDTH-1:0] req_funct3;
  logic [NUM_REQ-1:0]              req_funct7_fif;
  logic [NUM_REQ-1:0]              req_i_type;
  logic [NUM_REQ*XLEN-1:0]         req_op_a;
  logic [NUM_REQ*XLEN-1:0]         req_op_b;
  logic                            rsp_valid;
  logic                            rsp_ready;
  logic [ID_WIDTH-1:0]             rsp_id;
  logic [XLEN-1:0]                 rsp_data;
  logic                            busy;

  modport master (
    output req_valid, req_arith, req_funct3, req_funct7_fif, req_i_type,
           req_op_a, req_op_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_arith, req_funct3, req_funct7_fif, req_i_type,
           req_op_a, req_op_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/alu_core.sv
// Combinational RV32 ALU datapath: wrap-around arithmetic, shifts use
// op_b[4:0], compares return a zero-extended 0/1.
module alu_core
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]          op_a,
  input  logic [XLEN-1:0]          op_b,
  input  logic [ALUCTRL_WIDTH-1:0] alu_sel,
  output logic [XLEN-1:0]          result
);

  logic [4:0] shamt;
  assign shamt = op_b[4:0];

  // Select the operation result.
  always_comb begin
    result = '0;
    case (alu_sel)
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_AND:  result = op_a & op_b;
      ALU_OR:   result = op_a | op_b;
      ALU_XOR:  result = op_a ^ op_b;
      ALU_SLL:  result = op_a << shamt;
      ALU_SRL:  result = op_a >> shamt;
      ALU_SRA:  result = $unsigned($signed(op_a) >>> shamt);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters (0 = execute stage, 1 = address/
// branch helper). Round-robin arbitration, decode, and a one-entry response
// buffer with valid/ready backpressure.
// Build option: define ALU_ARB_FIXED_PRIO_EN to make req0 always win a
// contended cycle (no round-robin pointer is built in that case).
module alu_share_arbiter
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus
);

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] rsp_id_q, rsp_id_d;
  logic [XLEN-1:0]     rsp_data_q, rsp_data_d;

  logic                     grant;
  logic [ID_WIDTH-1:0]      win_id;
  logic                     sel_arith, sel_f7, sel_it;
  logic [FUNCT3_WIDTH-1:0]  sel_f3;
  logic [XLEN-1:0]          sel_a, sel_b;
  logic [ALUCTRL_WIDTH-1:0] alu_sel;
  logic [XLEN-1:0]          alu_result;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic rr_q, rr_d;
`endif

  // Arbitration: pick the winner and decide whether a grant may happen.
  always_comb begin
    win_id = '0;
    if (&bus.req_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      win_id = '0;
`else
      win_id = rr_q;
`endif
    end else begin
      win_id = bus.req_valid[1];
    end
    // A full buffer can accept a new result only when it drains this cycle.
    grant         = (|bus.req_valid) && ((state_q == ST_EMPTY) || bus.rsp_ready);
    bus.req_ready = grant ? (2'b01 << win_id) : 2'b00;
  end

  // Route the winning requester's fields to the decoder and the ALU.
  always_comb begin
    sel_arith = win_id[0] ? bus.req_arith[1]                 : bus.req_arith[0];
    sel_f3    = win_id[0] ? bus.req_funct3[5:3]              : bus.req_funct3[2:0];
    sel_f7    = win_id[0] ? bus.req_funct7_fif[1]            : bus.req_funct7_fif[0];
    sel_it    = win_id[0] ? bus.req_i_type[1]                : bus.req_i_type[0];
    sel_a     = win_id[0] ? bus.req_op_a[2*XLEN-1:XLEN]      : bus.req_op_a[XLEN-1:0];
    sel_b     = win_id[0] ? bus.req_op_b[2*XLEN-1:XLEN]      : bus.req_op_b[XLEN-1:0];
    alu_sel   = alu_decode(sel_arith, sel_f3, sel_f7, sel_it);
  end

  alu_core u_alu_core (
    .op_a    (sel_a),
    .op_b    (sel_b),
    .alu_sel (alu_sel),
    .result  (alu_result)
  );

  // Response buffer next state: load on grant, empty on drain, else hold.
  always_comb begin
    state_d    = state_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    if (grant) begin
      state_d    = ST_FULL;
      rsp_id_d   = win_id;
      rsp_data_d = alu_result;
    end else if ((state_q == ST_FULL) && bus.rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // Response buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin pointer points away from the most recent winner.
  always_comb begin
    rr_d = rr_q;
    if (grant) rr_d = ~win_id[0];
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
`endif

  assign bus.rsp_valid = (state_q == ST_FULL);
  assign bus.busy      = (state_q == ST_FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule
